// File: rtl/color_msg_tx.sv
// Colour message byte sequencer driving a UART transmitter via tx_start/tx_done.
// Define COLOR_MSG_CHECKSUM_EN to append a two-hex-char XOR checksum before the newline.
module color_msg_tx #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter logic        PARITY_TYPE    = 1'b0
) (
  input  logic       clk_3125,
  input  logic       reset,
  input  logic       msg_valid,
  input  logic [1:0] color_code,
  input  logic [7:0] intensity,
  input  logic       tx_done,
  output logic       msg_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       parity_type,
  output logic       msg_done,
  output logic       tx_err,
  output logic [7:0] drop_cnt
);

`ifdef COLOR_MSG_CHECKSUM_EN
  localparam int unsigned MSG_LEN = 7;
`else
  localparam int unsigned MSG_LEN = 5;
`endif
  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t        state;
  logic [2:0]    byte_idx;
  logic [1:0]    cap_color;
  logic [7:0]    cap_int;
  logic [TW-1:0] wait_cnt;
  logic [GW-1:0] gap_cnt;

  assign parity_type = PARITY_TYPE;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] color_char(input logic [1:0] c);
    case (c)
      2'b00:   return 8'h52;
      2'b01:   return 8'h47;
      2'b10:   return 8'h42;
      default: return 8'h57;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [1:0] col,
                                          input logic [7:0] inten);
    logic [7:0] cc;
`ifdef COLOR_MSG_CHECKSUM_EN
    logic [7:0] cs;
`endif
    cc = color_char(col);
`ifdef COLOR_MSG_CHECKSUM_EN
    cs = cc ^ hex_char(inten[7:4]) ^ hex_char(inten[3:0]);
`endif
    case (idx)
      3'd0:    msg_byte = 8'h23;
      3'd1:    msg_byte = cc;
      3'd2:    msg_byte = hex_char(inten[7:4]);
      3'd3:    msg_byte = hex_char(inten[3:0]);
`ifdef COLOR_MSG_CHECKSUM_EN
      3'd4:    msg_byte = hex_char(cs[7:4]);
      3'd5:    msg_byte = hex_char(cs[3:0]);
`endif
      default: msg_byte = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk_3125) begin
    if (reset) begin
      state     <= IDLE;
      msg_ready <= 1'b1;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      msg_done  <= 1'b0;
      tx_err    <= 1'b0;
      drop_cnt  <= '0;
      byte_idx  <= '0;
      cap_color <= '0;
      cap_int   <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      tx_start <= 1'b0;
      msg_done <= 1'b0;
      tx_err   <= 1'b0;
      if (msg_valid && !msg_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (msg_valid) begin
            // First byte is a constant, so it can be issued before the capture registers settle.
            cap_color <= color_code;
            cap_int   <= intensity;
            byte_idx  <= '0;
            tx_data   <= 8'h23;
            tx_start  <= 1'b1;
            msg_ready <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (byte_idx == LAST_IDX) begin
              msg_done  <= 1'b1;
              msg_ready <= 1'b1;
              state     <= IDLE;
            end else if (GAP_CYCLES == 0) begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= msg_byte(byte_idx + 3'd1, cap_color, cap_int);
              tx_start <= 1'b1;
              state    <= START;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              gap_cnt  <= '0;
              state    <= GAP;
            end
          end else if (wait_cnt == TO_LAST) begin
            tx_err    <= 1'b1;
            msg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            tx_data  <= msg_byte(byte_idx, cap_color, cap_int);
            tx_start <= 1'b1;
            state    <= START;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_msg_tx.sv
// Randomised bench for color_msg_tx: two instances (gap 2 / gap 0) checked every cycle
// against a timestamp-based message model, plus literal pins on logged traffic.
module tb_color_msg_tx;
`ifdef COLOR_MSG_CHECKSUM_EN
  localparam int MLEN = 7;
`else
  localparam int MLEN = 5;
`endif
  localparam int TO = 32;
  localparam int GAPV [2] = '{2, 0};
  localparam int PARV [2] = '{0, 1};

  logic clk_3125 = 1'b0;
  initial forever #5 clk_3125 = ~clk_3125;

  logic       reset, msg_valid, stray;
  logic [1:0] color_code;
  logic [7:0] intensity;
  logic       tx_done     [2];
  logic       msg_ready   [2];
  logic       tx_start    [2];
  logic       parity_type [2];
  logic       msg_done    [2];
  logic       tx_err      [2];
  logic [7:0] tx_data     [2];
  logic [7:0] drop_cnt    [2];

  color_msg_tx #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(32), .PARITY_TYPE(1'b0)) dut0 (
    .clk_3125(clk_3125), .reset(reset), .msg_valid(msg_valid), .color_code(color_code),
    .intensity(intensity), .tx_done(tx_done[0]), .msg_ready(msg_ready[0]),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .parity_type(parity_type[0]),
    .msg_done(msg_done[0]), .tx_err(tx_err[0]), .drop_cnt(drop_cnt[0]));

  color_msg_tx #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(32), .PARITY_TYPE(1'b1)) dut1 (
    .clk_3125(clk_3125), .reset(reset), .msg_valid(msg_valid), .color_code(color_code),
    .intensity(intensity), .tx_done(tx_done[1]), .msg_ready(msg_ready[1]),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .parity_type(parity_type[1]),
    .msg_done(msg_done[1]), .tx_err(tx_err[1]), .drop_cnt(drop_cnt[1]));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit armed = 0;

  // Behavioural model state: timestamps rather than states.
  bit         m_ready [2], m_start [2], m_done [2], m_err [2];
  logic [7:0] m_data  [2];
  int         m_drop [2], m_tst [2], m_wbeg [2], m_idx [2], m_col [2], m_int [2];

  // Traffic logs and responder control.
  int         st_cyc [2][1024];
  logic [7:0] st_dat [2][1024];
  int         sc [2], md [2], er [2], err_cyc [2], due [2], wh_at [2];
  int         fix_delay = 12;
  bit         rnd_delay = 0, wh_all = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic logic [7:0] msg_byte(input int i, input int col, input int inten);
    logic [7:0] cc, h, l, x;
    case (col)
      0: cc = 8'h52;
      1: cc = 8'h47;
      2: cc = 8'h42;
      default: cc = 8'h57;
    endcase
    h = hexc(inten / 16);
    l = hexc(inten % 16);
    x = cc ^ h ^ l;
    if (i == 0) return 8'h23;
    if (i == 1) return cc;
    if (i == 2) return h;
    if (i == 3) return l;
    if (MLEN == 7 && i == 4) return hexc(int'(x) / 16);
    if (MLEN == 7 && i == 5) return hexc(int'(x) % 16);
    return 8'h0A;
  endfunction

  // Advance the model over the edge ending cycle c, using that cycle's inputs.
  task automatic model_step(input int k, input int c);
    m_start[k] = 0; m_done[k] = 0; m_err[k] = 0;
    if (reset) begin
      m_ready[k] = 1; m_data[k] = 8'h00; m_drop[k] = 0;
      m_tst[k] = -1; m_wbeg[k] = -1; m_idx[k] = 0;
      return;
    end
    if (msg_valid && !m_ready[k] && m_drop[k] < 255) m_drop[k]++;
    if (msg_valid && m_ready[k]) begin
      m_col[k] = int'(color_code); m_int[k] = int'(intensity);
      m_idx[k] = 0; m_ready[k] = 0; m_tst[k] = c + 1;
    end else if (m_wbeg[k] >= 0 && c >= m_wbeg[k]) begin
      if (tx_done[k]) begin
        m_wbeg[k] = -1;
        if (m_idx[k] == MLEN - 1) begin
          m_ready[k] = 1; m_done[k] = 1;
        end else begin
          m_idx[k]++;
          m_tst[k] = c + 1 + GAPV[k];
        end
      end else if (c - m_wbeg[k] + 1 == TO) begin
        m_wbeg[k] = -1; m_err[k] = 1; m_ready[k] = 1;
      end
    end
    if (m_tst[k] == c + 1) begin
      m_start[k] = 1;
      m_data[k]  = msg_byte(m_idx[k], m_col[k], m_int[k]);
      m_wbeg[k]  = c + 2;
      m_tst[k]   = -1;
    end
  endtask

  // Model update, per-cycle compare, logging and tx_done scheduling.
  initial begin
    forever begin
      @(posedge clk_3125);
      for (int k = 0; k < 2; k++) model_step(k, cyc);
      if (reset) armed = 1;
      cyc++;
      #1;
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("msg_ready[%0d]", k), 32'(msg_ready[k]), 32'(m_ready[k]));
          chk($sformatf("tx_start[%0d]", k), 32'(tx_start[k]), 32'(m_start[k]));
          chk($sformatf("tx_data[%0d]", k), 32'(tx_data[k]), 32'(m_data[k]));
          chk($sformatf("msg_done[%0d]", k), 32'(msg_done[k]), 32'(m_done[k]));
          chk($sformatf("tx_err[%0d]", k), 32'(tx_err[k]), 32'(m_err[k]));
          chk($sformatf("drop_cnt[%0d]", k), 32'(drop_cnt[k]), 32'(m_drop[k]));
          chk($sformatf("parity_type[%0d]", k), 32'(parity_type[k]), 32'(PARV[k]));
          if (tx_start[k] === 1'b1 && sc[k] < 1024) begin
            st_cyc[k][sc[k]] = cyc;
            st_dat[k][sc[k]] = tx_data[k];
            if (!(wh_all || sc[k] == wh_at[k]))
              due[k] = cyc + (rnd_delay ? int'($urandom_range(1, 34)) : fix_delay);
            sc[k]++;
          end
          if (msg_done[k] === 1'b1) md[k]++;
          if (tx_err[k] === 1'b1) begin er[k]++; err_cyc[k] = cyc; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_3125);
      for (int k = 0; k < 2; k++) tx_done[k] = (due[k] == cyc) || stray;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int limit, input bit noise);
    for (int i = 0; i < limit && !(msg_ready[0] && msg_ready[1]); i++) begin
      @(negedge clk_3125);
      color_code = 2'($urandom);
      intensity  = 8'($urandom);
      msg_valid  = noise && ($urandom_range(0, 7) == 0) && !msg_ready[0] && !msg_ready[1];
    end
    msg_valid = 1'b0;
    chk("wait_idle", 32'(msg_ready[0] && msg_ready[1]), 32'd1);
  endtask

  task automatic send(input logic [1:0] col, input logic [7:0] inten);
    wait_idle(2000, 1'b0);
    msg_valid = 1'b1; color_code = col; intensity = inten;
    @(negedge clk_3125);
    msg_valid = 1'b0; color_code = 2'($urandom); intensity = 8'($urandom);
  endtask

  logic [7:0] exp_a [MLEN];
  int b [2], m0 [2], e0 [2], s0 [2];

  initial begin
`ifdef COLOR_MSG_CHECKSUM_EN
    exp_a = '{8'h23, 8'h47, 8'h41, 8'h35, 8'h33, 8'h33, 8'h0A};
`else
    exp_a = '{8'h23, 8'h47, 8'h41, 8'h35, 8'h0A};
`endif
    reset = 1'b1; msg_valid = 1'b0; stray = 1'b0; color_code = '0; intensity = '0;
    for (int k = 0; k < 2; k++) begin
      tx_done[k] = 1'b0; due[k] = -1; wh_at[k] = -1; sc[k] = 0; md[k] = 0; er[k] = 0;
    end
    repeat (3) @(negedge clk_3125);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(msg_ready[k]), 32'd1);
      chk("reset_data", 32'(tx_data[k]), 32'h00);
      chk("reset_drop", 32'(drop_cnt[k]), 32'd0);
    end
    reset = 1'b0;

    // Fixed message 'G', 0xA5, 12-cycle transmitter.
    fix_delay = 12;
    for (int k = 0; k < 2; k++) begin b[k] = sc[k]; m0[k] = md[k]; end
    send(2'b01, 8'hA5);
    wait_idle(2000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < MLEN; i++) chk($sformatf("msgA[%0d][%0d]", k, i), 32'(st_dat[k][b[k]+i]), 32'(exp_a[i]));
      chk("msgA_done_count", 32'(md[k] - m0[k]), 32'd1);
    end

    // Intensity 0x09: digit chars and tx_done-to-tx_start spacing.
    fix_delay = int'($urandom_range(1, 20));
    for (int k = 0; k < 2; k++) b[k] = sc[k];
    send(2'($urandom), 8'h09);
    wait_idle(2000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("nib_hi", 32'(st_dat[k][b[k]+2]), 32'h30);
      chk("nib_lo", 32'(st_dat[k][b[k]+3]), 32'h39);
      for (int i = 0; i < MLEN - 1; i++)
        chk($sformatf("done_to_start[%0d]", k), 32'(st_cyc[k][b[k]+i+1] - st_cyc[k][b[k]+i] - fix_delay),
            (k == 0) ? 32'd3 : 32'd1);
    end

    // Timeout: second byte never completes.
    fix_delay = 12;
    for (int k = 0; k < 2; k++) begin b[k] = sc[k]; wh_at[k] = sc[k] + 1; m0[k] = md[k]; e0[k] = er[k]; end
    send(2'($urandom), 8'($urandom));
    wait_idle(2000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("timeout_err_count", 32'(er[k] - e0[k]), 32'd1);
      chk("timeout_no_done", 32'(md[k] - m0[k]), 32'd0);
      chk("timeout_latency", 32'(err_cyc[k] - st_cyc[k][b[k]+1]), 32'd33);
      chk("timeout_starts", 32'(sc[k] - b[k]), 32'd2);
      wh_at[k] = -1;
    end

    // Drops while busy, then saturation.
    send(2'($urandom), 8'($urandom));
    repeat (3) begin
      msg_valid = 1'b1; @(negedge clk_3125);
      msg_valid = 1'b0; @(negedge clk_3125);
    end
    wait_idle(2000, 1'b0);
    for (int k = 0; k < 2; k++) chk("drop_three", 32'(drop_cnt[k]), 32'd3);
    wh_all = 1'b1;
    msg_valid = 1'b1;
    repeat (400) begin
      @(negedge clk_3125);
      color_code = 2'($urandom); intensity = 8'($urandom);
    end
    msg_valid = 1'b0;
    wh_all = 1'b0;
    wait_idle(2000, 1'b0);
    for (int k = 0; k < 2; k++) chk("drop_saturate", 32'(drop_cnt[k]), 32'd255);

    // Reset during WAIT_DONE of byte 3, with msg_valid held during reset.
    fix_delay = 12;
    b[0] = sc[0];
    send(2'($urandom), 8'($urandom));
    for (int i = 0; i < 500 && sc[0] < b[0] + 3; i++) @(negedge clk_3125);
    chk("reach_byte3", 32'(sc[0] - b[0]), 32'd3);
    repeat (2) @(negedge clk_3125);
    reset = 1'b1; msg_valid = 1'b1;
    @(negedge clk_3125);
    reset = 1'b0; msg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_start", 32'(tx_start[k]), 32'd0);
      chk("midrst_ready", 32'(msg_ready[k]), 32'd1);
      chk("midrst_data", 32'(tx_data[k]), 32'h00);
      chk("midrst_drop", 32'(drop_cnt[k]), 32'd0);
      s0[k] = sc[k]; m0[k] = md[k]; e0[k] = er[k];
    end
    repeat (40) begin
      stray = 1'($urandom);
      @(negedge clk_3125);
    end
    stray = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_no_start", 32'(sc[k] - s0[k]), 32'd0);
      chk("midrst_no_done", 32'(md[k] - m0[k]), 32'd0);
      chk("midrst_no_err", 32'(er[k] - e0[k]), 32'd0);
    end

    // Random messages, random transmitter latency (including timeout boundary), drop noise.
    rnd_delay = 1'b1;
    repeat (12) begin
      send(2'($urandom), 8'($urandom));
      wait_idle(3000, 1'b1);
    end
    rnd_delay = 1'b0;
    repeat (3) @(negedge clk_3125);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
